mem_bus_arbiter: RTL and testbench

- Shared main-memory model and bus arbiter sitting directly downstream of the two snooping caches.
- Accepts each cache's rwToMem/addrToMem/dataToMem request and buffers one request per port.
- Grants the bus round-robin, models a fixed memory latency, and returns readEnFromMem/dataFromMem or writeDoneFromMem to the requester.
- Serialises all memory traffic, so the write-back then re-read sequences the caches perform on snoop misses are ordered.

---
 rtl/mem_bus_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Shared main memory behind a two-port round-robin bus arbiter.
// Each cache port buffers one request; accesses are serialised with a fixed latency.
module mem_bus_arbiter #(
   parameter int IOSTATEWIDTH = 2,
   parameter int ADDRWIDTH    = 8,
   parameter int WORDWIDTH    = 32,
   parameter int DEPTH        = 256,
   parameter int MEM_LAT      = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [IOSTATEWIDTH-1:0] rw0,
   input  logic [ADDRWIDTH-1:0]    addr0,
   input  logic [WORDWIDTH-1:0]    wdata0,
   input  logic [IOSTATEWIDTH-1:0] rw1,
   input  logic [ADDRWIDTH-1:0]    addr1,
   input  logic [WORDWIDTH-1:0]    wdata1,
   output logic                    readEn0,
   output logic                    writeDone0,
   output logic [WORDWIDTH-1:0]    rdata0,
   output logic                    readEn1,
   output logic                    writeDone1,
   output logic [WORDWIDTH-1:0]    rdata1,
   output logic                    busy,
   output logic                    grant,
   output logic                    ovf0,
   output logic                    ovf1
);

   localparam logic [IOSTATEWIDTH-1:0] IDEL = IOSTATEWIDTH'(0);
   localparam logic [IOSTATEWIDTH-1:0] RD   = IOSTATEWIDTH'(1);
   localparam logic [IOSTATEWIDTH-1:0] WT   = IOSTATEWIDTH'(2);
   localparam int IDXW = $clog2(DEPTH);
   localparam int CNTW = 4;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RESP
   } stateT;

   stateT state, nextState;

   logic [WORDWIDTH-1:0]    mem [DEPTH];
   logic                    pend0, pend1;
   logic [IOSTATEWIDTH-1:0] slotRw0, slotRw1;
   logic [ADDRWIDTH-1:0]    slotAddr0, slotAddr1;
   logic [WORDWIDTH-1:0]    slotData0, slotData1;
   logic                    lastGrant;
   logic [CNTW-1:0]         cnt;

   logic                    free0, free1;
   logic                    req0, req1;
   logic                    illegal0, illegal1;
   logic                    cand0, cand1;
   logic                    doGrant, winner;
   logic                    finish;
   logic [IOSTATEWIDTH-1:0] selRw;
   logic [ADDRWIDTH-1:0]    selAddr;
   logic [WORDWIDTH-1:0]    selData;
   logic [IDXW-1:0]         selIdx;

   // A slot is reusable during its own response cycle, so a cache may chain requests.
   assign free0    = !pend0 || (state == RESP && !grant);
   assign free1    = !pend1 || (state == RESP && grant);
   assign req0     = (rw0 == RD) || (rw0 == WT);
   assign req1     = (rw1 == RD) || (rw1 == WT);
   assign illegal0 = !(req0 || rw0 == IDEL);
   assign illegal1 = !(req1 || rw1 == IDEL);

   assign cand0 = pend0 && (state == IDLE || (state == RESP && grant));
   assign cand1 = pend1 && (state == IDLE || (state == RESP && !grant));

   assign finish  = (state == BUSY) && (cnt == '0);
   assign selRw   = grant ? slotRw1 : slotRw0;
   assign selAddr = grant ? slotAddr1 : slotAddr0;
   assign selData = grant ? slotData1 : slotData0;
   assign selIdx  = selAddr[IDXW-1:0];

   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= nextState;
   end

   always_comb begin
      nextState = state;
      doGrant   = 1'b0;
      winner    = grant;
      case (state)
         IDLE, RESP: begin
            if (cand0 || cand1) begin
               doGrant   = 1'b1;
               nextState = BUSY;
               winner    = (cand0 && cand1) ? ~lastGrant : cand1;
            end else begin
               nextState = IDLE;
            end
         end
         BUSY: begin
            if (cnt == '0)
               nextState = RESP;
         end
         default: nextState = IDLE;
      endcase
   end

   // Slot bookkeeping, counters, response pulses and read data.
   always_ff @(posedge clk) begin
      if (reset) begin
         pend0      <= 1'b0;
         pend1      <= 1'b0;
         slotRw0    <= IDEL;
         slotRw1    <= IDEL;
         slotAddr0  <= '0;
         slotAddr1  <= '0;
         slotData0  <= '0;
         slotData1  <= '0;
         lastGrant  <= 1'b1;
         grant      <= 1'b0;
         cnt        <= '0;
         busy       <= 1'b0;
         ovf0       <= 1'b0;
         ovf1       <= 1'b0;
         readEn0    <= 1'b0;
         writeDone0 <= 1'b0;
         readEn1    <= 1'b0;
         writeDone1 <= 1'b0;
         rdata0     <= '0;
         rdata1     <= '0;
      end else begin
         busy <= (nextState != IDLE);

         if (doGrant) begin
            grant     <= winner;
            lastGrant <= winner;
            cnt       <= CNTW'(MEM_LAT - 1);
         end else if (state == BUSY && cnt != '0) begin
            cnt <= cnt - 1'b1;
         end

         if (free0 && req0) begin
            pend0     <= 1'b1;
            slotRw0   <= rw0;
            slotAddr0 <= addr0;
            slotData0 <= wdata0;
         end else if (state == RESP && !grant) begin
            pend0 <= 1'b0;
         end

         if (free1 && req1) begin
            pend1     <= 1'b1;
            slotRw1   <= rw1;
            slotAddr1 <= addr1;
            slotData1 <= wdata1;
         end else if (state == RESP && grant) begin
            pend1 <= 1'b0;
         end

         ovf0 <= ovf0 | illegal0 | (req0 && !free0);
         ovf1 <= ovf1 | illegal1 | (req1 && !free1);

         readEn0    <= finish && !grant && selRw == RD;
         writeDone0 <= finish && !grant && selRw == WT;
         readEn1    <= finish && grant && selRw == RD;
         writeDone1 <= finish && grant && selRw == WT;

         if (finish && selRw == RD) begin
            if (grant)
               rdata1 <= mem[selIdx];
            else
               rdata0 <= mem[selIdx];
         end
      end
   end

   // Memory contents survive reset; a write aborted by reset never lands.
   always_ff @(posedge clk) begin
      if (!reset && finish && selRw == WT)
         mem[selIdx] <= selData;
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: expected responses are queued when a
// request is driven and matched against every readEn/writeDone pulse.
module tb_mem_bus_arbiter;

   localparam logic [1:0] IDEL = 2'd0;
   localparam logic [1:0] RD   = 2'd1;
   localparam logic [1:0] WT   = 2'd2;
   localparam logic [1:0] ILL  = 2'd3;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  rw0, rw1;
   logic [7:0]  addr0, addr1;
   logic [31:0] wdata0, wdata1;
   logic        readEn0, writeDone0, readEn1, writeDone1;
   logic [31:0] rdata0, rdata1;
   logic        busy, grant, ovf0, ovf1;

   typedef struct {
      int          port;
      int          isRead;
      logic [31:0] data;
      int          due;
   } RespT;

   RespT scoreQ[$];
   RespT monE;
   int   monPort, monRead;
   int   compared   = 0;
   int   mismatched = 0;
   int   cyc        = 0;
   int   n0, n1;

   mem_bus_arbiter #(
      .IOSTATEWIDTH(2),
      .ADDRWIDTH(8),
      .WORDWIDTH(32),
      .DEPTH(256),
      .MEM_LAT(4)
   ) dut (
      .clk(clk),
      .reset(reset),
      .rw0(rw0),
      .addr0(addr0),
      .wdata0(wdata0),
      .rw1(rw1),
      .addr1(addr1),
      .wdata1(wdata1),
      .readEn0(readEn0),
      .writeDone0(writeDone0),
      .rdata0(rdata0),
      .readEn1(readEn1),
      .writeDone1(writeDone1),
      .rdata1(rdata1),
      .busy(busy),
      .grant(grant),
      .ovf0(ovf0),
      .ovf1(ovf1)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cyc);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic idleInputs();
      rw0 = IDEL;
      rw1 = IDEL;
   endtask

   // Drives one port's request; dueOffset > 0 queues the expected response.
   task automatic applyStimulus(input int port, input logic [1:0] rw, input logic [7:0] addr,
                                input logic [31:0] wd, input logic [31:0] expData, input int dueOffset);
      RespT item;
      if (port == 0) begin
         rw0 = rw; addr0 = addr; wdata0 = wd;
      end else begin
         rw1 = rw; addr1 = addr; wdata1 = wd;
      end
      if (dueOffset > 0) begin
         item.port   = port;
         item.isRead = (rw == RD) ? 1 : 0;
         item.data   = expData;
         item.due    = cyc + dueOffset;
         scoreQ.push_back(item);
      end
   endtask

   task automatic doReset();
      reset = 1'b1;
      idleInputs();
      step(2);
      reset = 1'b0;
   endtask

   task automatic drain(input int maxCycles);
      int n = 0;
      while (scoreQ.size() != 0 && n < maxCycles) begin
         step(1);
         n++;
      end
      if (scoreQ.size() != 0) begin
         checkOutput("drainTimeout", 32'(scoreQ.size()), 32'd0);
         scoreQ.delete();
      end
   endtask

   // Every response pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (readEn0 | writeDone0 | readEn1 | writeDone1) begin
         checkOutput("singlePulse", 32'(readEn0) + 32'(writeDone0) + 32'(readEn1) + 32'(writeDone1), 32'd1);
         if (scoreQ.size() == 0) begin
            checkOutput("unexpectedPulse", {28'd0, readEn0, writeDone0, readEn1, writeDone1}, 32'd0);
         end else begin
            monE    = scoreQ.pop_front();
            monPort = (readEn1 | writeDone1) ? 1 : 0;
            monRead = (readEn0 | readEn1) ? 1 : 0;
            checkOutput("respPort", 32'(monPort), 32'(monE.port));
            checkOutput("respKind", 32'(monRead), 32'(monE.isRead));
            checkOutput("respCycle", 32'(cyc), 32'(monE.due));
            checkOutput("respGrant", 32'(grant), 32'(monE.port));
            if (monE.isRead != 0)
               checkOutput("respData", (monPort == 1) ? rdata1 : rdata0, monE.data);
         end
      end
   end

   initial begin
      reset = 1'b1;
      rw0 = IDEL; addr0 = '0; wdata0 = '0;
      rw1 = IDEL; addr1 = '0; wdata1 = '0;
      step(3);
      checkOutput("rstReadEn0", 32'(readEn0), 32'd0);
      checkOutput("rstWriteDone0", 32'(writeDone0), 32'd0);
      checkOutput("rstReadEn1", 32'(readEn1), 32'd0);
      checkOutput("rstWriteDone1", 32'(writeDone1), 32'd0);
      checkOutput("rstRdata0", rdata0, 32'd0);
      checkOutput("rstRdata1", rdata1, 32'd0);
      checkOutput("rstBusy", 32'(busy), 32'd0);
      checkOutput("rstGrant", 32'(grant), 32'd0);
      checkOutput("rstOvf0", 32'(ovf0), 32'd0);
      checkOutput("rstOvf1", 32'(ovf1), 32'd0);
      reset = 1'b0;
      step(1);

      // Single uncontended write: busy for five cycles, pulse five edges after capture.
      $display("[TB] single write");
      applyStimulus(0, WT, 8'h10, 32'hDEADBEEF, 32'h0, 6);
      step(1);
      idleInputs();
      checkOutput("busyBeforeGrant", 32'(busy), 32'd0);
      step(1);
      for (int i = 0; i < 5; i++) begin
         checkOutput("busyWindow", 32'(busy), 32'd1);
         checkOutput("grantWindow", 32'(grant), 32'd0);
         step(1);
      end
      checkOutput("busyAfter", 32'(busy), 32'd0);
      drain(20);

      // Read back the written word; it must stay on rdata0 afterwards.
      $display("[TB] read back");
      applyStimulus(0, RD, 8'h10, 32'h0, 32'hDEADBEEF, 6);
      step(1);
      idleInputs();
      drain(20);
      step(3);
      checkOutput("rdata0Hold", rdata0, 32'hDEADBEEF);
      checkOutput("rdata1Quiet", rdata1, 32'd0);

      // Simultaneous write (port 0) and read (port 1) of the same word after reset.
      $display("[TB] contention");
      doReset();
      step(1);
      applyStimulus(0, WT, 8'h20, 32'h1, 32'h0, 6);
      applyStimulus(1, RD, 8'h20, 32'h0, 32'h1, 11);
      step(1);
      idleInputs();
      drain(30);

      // Both ports re-issue reads on each of their own response pulses.
      $display("[TB] back-to-back");
      step(1);
      applyStimulus(0, RD, 8'h10, 32'h0, 32'hDEADBEEF, 6);
      applyStimulus(1, RD, 8'h20, 32'h0, 32'h1, 11);
      n0 = 1;
      n1 = 1;
      step(1);
      idleInputs();
      for (int i = 0; i < 40; i++) begin
         step(1);
         idleInputs();
         if (readEn0 && n0 < 3) begin
            applyStimulus(0, RD, 8'h10, 32'h0, 32'hDEADBEEF, 10);
            n0++;
         end
         if (readEn1 && n1 < 3) begin
            applyStimulus(1, RD, 8'h20, 32'h0, 32'h1, 10);
            n1++;
         end
      end
      drain(20);
      checkOutput("b2bIssued0", 32'(n0), 32'd3);
      checkOutput("b2bIssued1", 32'(n1), 32'd3);
      checkOutput("b2bOvf0", 32'(ovf0), 32'd0);
      checkOutput("b2bOvf1", 32'(ovf1), 32'd0);

      // Request while the port's slot is busy is dropped and latches ovf1.
      $display("[TB] overflow");
      applyStimulus(1, RD, 8'h20, 32'h0, 32'h1, 6);
      step(1);
      idleInputs();
      step(2);
      applyStimulus(1, RD, 8'h10, 32'h0, 32'h0, 0);
      step(1);
      idleInputs();
      checkOutput("ovf1Set", 32'(ovf1), 32'd1);
      checkOutput("ovf0Clear", 32'(ovf0), 32'd0);
      drain(20);
      step(8);
      checkOutput("ovf1Sticky", 32'(ovf1), 32'd1);
      applyStimulus(0, ILL, 8'h10, 32'h0, 32'h0, 0);
      step(1);
      idleInputs();
      checkOutput("ovf0Illegal", 32'(ovf0), 32'd1);
      step(8);
      checkOutput("illegalNoBusy", 32'(busy), 32'd0);
      doReset();
      checkOutput("ovf0AfterRst", 32'(ovf0), 32'd0);
      checkOutput("ovf1AfterRst", 32'(ovf1), 32'd0);

      // Reset during a write's BUSY phase must abort it without touching memory.
      $display("[TB] reset abort");
      step(1);
      applyStimulus(0, WT, 8'h30, 32'h5, 32'h0, 6);
      step(1);
      idleInputs();
      drain(20);
      step(1);
      applyStimulus(0, WT, 8'h30, 32'h99, 32'h0, 0);
      step(1);
      idleInputs();
      step(2);
      checkOutput("abortBusyBefore", 32'(busy), 32'd1);
      reset = 1'b1;
      step(1);
      checkOutput("abortBusy", 32'(busy), 32'd0);
      checkOutput("abortWriteDone", 32'(writeDone0), 32'd0);
      reset = 1'b0;
      step(8);
      applyStimulus(0, RD, 8'h30, 32'h0, 32'h5, 6);
      step(1);
      idleInputs();
      drain(20);
      step(2);
      checkOutput("queueEmpty", 32'(scoreQ.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
